// File: rtl/io_port_unit_if.sv
// rtl/io_port_unit_if.sv - CPU/pin-side bundle for io_port_unit
// Ports (slave = io_port_unit side):
//   in_port/in_valid/in_ready       external input word handshake
//   rd_en/rd_data/rd_empty          CPU IN: show-ahead FIFO head and pop
//   wr_en/wr_ch/wr_data             CPU OUT: channel write
//   out_port/out_strobe             registered channels and write pulses
//   err                             sticky {bad channel, underflow}
interface io_port_unit_if #(
  parameter int DATA_W = 16,
  parameter int N_OUT  = 2,
  parameter int CH_W   = 4
);
  logic [DATA_W-1:0]       in_port;
  logic                    in_valid;
  logic                    in_ready;
  logic                    rd_en;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_empty;
  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  logic [DATA_W-1:0]       wr_data;
  logic [N_OUT*DATA_W-1:0] out_port;
  logic [N_OUT-1:0]        out_strobe;
  logic [1:0]              err;

  modport master (
    output in_port, in_valid, rd_en, wr_en, wr_ch, wr_data,
    input  in_ready, rd_data, rd_empty, out_port, out_strobe, err
  );

  modport slave (
    input  in_port, in_valid, rd_en, wr_en, wr_ch, wr_data,
    output in_ready, rd_data, rd_empty, out_port, out_strobe, err
  );
endinterface

// File: rtl/io_port_unit.sv
// rtl/io_port_unit.sv - input FIFO, output channel registers and sticky errors
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   io_port_unit_if.slave (input handshake, CPU IN/OUT, err)
module io_port_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int N_OUT  = 2,
  parameter int CH_W   = 4
) (
  input logic            clk,
  input logic            rst,
  io_port_unit_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_C  = (PW+1)'(DEPTH);
  localparam logic [CH_W:0] N_OUT_C = (CH_W+1)'(N_OUT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              push;
  logic              pop;
  logic              wr_ok;

  // in_ready is gated by rst so a word offered during reset is never taken.
  assign bus.in_ready = rst & (count != FULL_C);
  assign bus.rd_empty = (count == '0);
  assign bus.rd_data  = bus.rd_empty ? '0 : mem[rd_ptr];

  assign push  = bus.in_valid & bus.in_ready;
  // rd_empty blocks the pop, so push+pop on an empty FIFO is push-only.
  assign pop   = bus.rd_en & ~bus.rd_empty;
  assign wr_ok = bus.wr_en & ({1'b0, bus.wr_ch} < N_OUT_C);

  // Storage is not reset; pointers/count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_port;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_port   <= '0;
      bus.out_strobe <= '0;
    end else begin
      // Strobe is a single-cycle pulse unless the channel is written again.
      bus.out_strobe <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_ok && (bus.wr_ch == CH_W'(k))) begin
          bus.out_port[k*DATA_W +: DATA_W] <= bus.wr_data;
          bus.out_strobe[k]                <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.err <= '0;
    end else begin
      if (bus.rd_en && bus.rd_empty) begin
        bus.err[0] <= 1'b1;
      end
      if (bus.wr_en && !wr_ok) begin
        bus.err[1] <= 1'b1;
      end
    end
  end
endmodule
